mult_share_arb: RTL and testbench

MULT_SHARE_ARB -- requirements
Module: mult_share_arb

---
 rtl/mult_share_arb.sv | 108 ++++++++++
 tb/tb_mult_share_arb.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arb.sv
// Two-requester front end for one shared pipelined 8ux8s multiplier.
// Round-robin grant, operand registers, and a tag pipeline for responses.
module mult_share_arb #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        req1_ready,
  output logic [7:0]  mul_n1,
  output logic [7:0]  mul_n2,
  input  logic [15:0] mul_result,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic        busy
);

  // prio_q names the side that wins the next conflict
  logic         prio_q, prio_d;
  logic [7:0]   n1_q, n1_d;
  logic [7:0]   n2_q, n2_d;
  // tag stage 0 lines up with the operand regs,
  // stage LAT lines up with mul_result
  logic [LAT:0] tv_q, tv_d;
  logic [LAT:0] tid_q, tid_d;
  logic         rv_q;
  logic         rid_q;
  logic [15:0]  rd_q;

  logic         gnt0;
  logic         gnt1;
  logic         acc;
  logic         acc_id;

  // grant decision; nothing is granted while in reset
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      unique case ({req1_valid, req0_valid})
        2'b01: gnt0 = 1'b1;
        2'b10: gnt1 = 1'b1;
        2'b11: begin
          gnt0 = ~prio_q;
          gnt1 = prio_q;
        end
        default: ;
      endcase
    end
  end

  assign acc        = gnt0 | gnt1;
  assign acc_id     = gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // next state: operands, priority flip and tag shift
  always_comb begin
    prio_d = prio_q;
    n1_d   = n1_q;
    n2_d   = n2_q;
    if (acc) begin
      prio_d = ~acc_id;
      n1_d   = gnt1 ? req1_a : req0_a;
      n2_d   = gnt1 ? req1_b : req0_b;
    end
    tv_d  = {tv_q[LAT-1:0], acc};
    tid_d = {tid_q[LAT-1:0], acc_id};
  end

  // state registers; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
      n1_q   <= '0;
      n2_q   <= '0;
      tv_q   <= '0;
      tid_q  <= '0;
      rv_q   <= 1'b0;
      rid_q  <= 1'b0;
      rd_q   <= '0;
    end else begin
      prio_q <= prio_d;
      n1_q   <= n1_d;
      n2_q   <= n2_d;
      tv_q   <= tv_d;
      tid_q  <= tid_d;
      rv_q   <= tv_q[LAT];
      rid_q  <= tid_q[LAT];
      rd_q   <= mul_result;
    end
  end

  assign mul_n1    = n1_q;
  assign mul_n2    = n2_q;
  assign rsp_valid = rv_q;
  assign rsp_id    = rid_q;
  assign rsp_data  = rd_q;
  assign busy      = (|tv_q) | rv_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb with a LAT=2 multiplier model.
// Table vectors, corner sequences and a random run vs a queue model.
module tb_mult_share_arb;

  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic [7:0]  req0_a;
  logic [7:0]  req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic [7:0]  req1_a;
  logic [7:0]  req1_b;
  logic        req1_ready;
  logic [7:0]  mul_n1;
  logic [7:0]  mul_n2;
  logic [15:0] mul_result;
  logic        rsp_valid;
  logic        rsp_id;
  logic [15:0] rsp_data;
  logic        busy;

  mult_share_arb #(.LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .mul_n1     (mul_n1),
    .mul_n2     (mul_n2),
    .mul_result (mul_result),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // shared mult8ux8s stand-in: product appears LAT edges after operands
  logic [15:0] mp [LAT];
  always @(posedge clk) begin
    mp[0] <= $signed({1'b0, mul_n1}) * $signed(mul_n2);
    for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
  end
  assign mul_result = mp[LAT-1];

  typedef struct {
    int          due;
    bit          id;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    bit          r;
    bit          v0;
    logic [7:0]  a0;
    logic [7:0]  b0;
    bit          v1;
    logic [7:0]  a1;
    logic [7:0]  b1;
    bit          er0;
    bit          er1;
    logic [15:0] ep;
  } vec_t;

  int     checks;
  int     errors;
  int     edge_no;
  exp_t   q[$];
  bit     m_pref;
  logic [7:0] m_n1;
  logic [7:0] m_n2;
  vec_t   tbl[$];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_prod(input logic [7:0] a,
                                           input logic [7:0] b);
    int pa;
    int pb;
    int p;
    pa = int'(a);
    pb = int'($signed(b));
    p  = pa * pb;
    return p[15:0];
  endfunction

  // one clock: drive, check ready, step the model, check outputs
  task automatic cycle(input vec_t v, input bit ck, input bit cp);
    bit          g_ok;
    bit          gid;
    logic [15:0] prod;
    bit          exp_v;
    exp_t        e;
    @(negedge clk);
    rst        = v.r;
    req0_valid = v.v0;
    req0_a     = v.a0;
    req0_b     = v.b0;
    req1_valid = v.v1;
    req1_a     = v.a1;
    req1_b     = v.b1;
    #1;
    g_ok = 1'b0;
    gid  = 1'b0;
    if (!v.r) begin
      if (v.v0 && v.v1) begin
        g_ok = 1'b1;
        gid  = m_pref;
      end else if (v.v0) begin
        g_ok = 1'b1;
      end else if (v.v1) begin
        g_ok = 1'b1;
        gid  = 1'b1;
      end
    end
    chk("ready0", req0_ready, g_ok && !gid);
    chk("ready1", req1_ready, g_ok && gid);
    if (ck) begin
      chk("tbl_ready0", req0_ready, v.er0);
      chk("tbl_ready1", req1_ready, v.er1);
    end
    if (g_ok) begin
      if (cp) prod = v.ep;
      else prod = gid ? ref_prod(v.a1, v.b1) : ref_prod(v.a0, v.b0);
      q.push_back('{edge_no + 1 + LAT + 1, gid, prod});
      m_pref = !gid;
      m_n1   = gid ? v.a1 : v.a0;
      m_n2   = gid ? v.b1 : v.b0;
    end
    @(posedge clk);
    edge_no++;
    #1;
    if (v.r) begin
      q.delete();
      m_pref = 1'b0;
      m_n1   = '0;
      m_n2   = '0;
      chk("rst_rsp_data", rsp_data, 16'h0);
      chk("rst_rsp_id", rsp_id, 1'b0);
    end
    exp_v = (q.size() > 0) && (q[0].due == edge_no);
    chk("busy", busy, q.size() > 0);
    chk("rsp_valid", rsp_valid, exp_v);
    if (exp_v) begin
      e = q.pop_front();
      chk("rsp_id", rsp_id, e.id);
      chk("rsp_data", rsp_data, e.data);
    end
    chk("mul_n1", mul_n1, m_n1);
    chk("mul_n2", mul_n2, m_n2);
  endtask

  vec_t rv;
  vec_t iv;

  initial begin
    checks     = 0;
    errors     = 0;
    edge_no    = 0;
    m_pref     = 1'b0;
    m_n1       = '0;
    m_n2       = '0;
    rst        = 1'b1;
    req0_valid = 1'b0;
    req0_a     = '0;
    req0_b     = '0;
    req1_valid = 1'b0;
    req1_a     = '0;
    req1_b     = '0;

    rv = '{1, 1, 8'h00, 8'h00, 1, 8'h00, 8'h00, 0, 0, 16'h0};
    iv = '{0, 0, 8'h12, 8'h34, 0, 8'h56, 8'h78, 0, 0, 16'h0};

    tbl.push_back(rv);
    tbl.push_back('{0, 1, 8'h55, 8'h55, 0, 8'h00, 8'h00,
                    1, 0, 16'h1C39});
    for (int i = 0; i < 4; i++) tbl.push_back(iv);
    tbl.push_back(rv);
    for (int i = 0; i < 2; i++) begin
      tbl.push_back('{0, 1, 8'hFF, 8'h80, 1, 8'hAA, 8'hAA,
                      1, 0, 16'h8080});
      tbl.push_back('{0, 1, 8'hFF, 8'h80, 1, 8'hAA, 8'hAA,
                      0, 1, 16'hC6E4});
    end
    for (int i = 0; i < 4; i++) tbl.push_back(iv);
    tbl.push_back('{0, 0, 8'h00, 8'h00, 1, 8'hFF, 8'h81,
                    0, 1, 16'h817F});
    tbl.push_back('{0, 1, 8'hFF, 8'h80, 1, 8'hAA, 8'hAA,
                    1, 0, 16'h8080});
    for (int i = 0; i < 4; i++) tbl.push_back(iv);
    tbl.push_back('{0, 1, 8'hFF, 8'h00, 0, 8'h00, 8'h00,
                    1, 0, 16'h0000});
    tbl.push_back('{0, 0, 8'h00, 8'h00, 1, 8'h00, 8'h7F,
                    0, 1, 16'h0000});
    tbl.push_back('{0, 1, 8'hFF, 8'h7F, 0, 8'h00, 8'h00,
                    1, 0, 16'h7E81});
    for (int i = 0; i < 5; i++) tbl.push_back(iv);

    foreach (tbl[i]) cycle(tbl[i], 1'b1, 1'b1);

    // reset while two products are still in the pipe
    cycle(rv, 1'b1, 1'b0);
    cycle('{0, 1, 8'h12, 8'h34, 0, 8'h00, 8'h00, 1, 0, 16'h0},
          1'b1, 1'b0);
    cycle('{0, 0, 8'h00, 8'h00, 1, 8'h56, 8'h78, 0, 1, 16'h0},
          1'b1, 1'b0);
    cycle('{1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 16'h0},
          1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(iv, 1'b1, 1'b0);
    cycle('{0, 1, 8'h03, 8'hFD, 1, 8'h04, 8'h05, 1, 0, 16'h0},
          1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(iv, 1'b1, 1'b0);

    // operand wiggle with no valid must be ignored
    for (int i = 0; i < 10; i++) begin
      vec_t w;
      w = '{0, 0, 8'($urandom), 8'($urandom),
            0, 8'($urandom), 8'($urandom), 0, 0, 16'h0};
      cycle(w, 1'b1, 1'b0);
    end

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      vec_t w;
      w = '{($urandom_range(0, 63) == 0),
            ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 2) != 0), 8'($urandom), 8'($urandom),
            0, 0, 16'h0};
      cycle(w, 1'b0, 1'b0);
    end
    for (int i = 0; i < 6; i++) cycle(iv, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
